// File: rtl/dct_strip_scheduler.sv
// Strip scheduler for the five-engine DCT array: detects ingester bank swaps, steps the
// engines through the MCU groups of a strip and keeps credits on the shared output ring.
module dct_strip_scheduler #(
    parameter int NUM_DCTS         = 5,
    parameter int GROUPS_PER_STRIP = 8,
    parameter int RESET_CYCLES     = 3,
    parameter int OUT_SLOTS        = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                ingester_frontbuffer_select,
    input  logic [NUM_DCTS-1:0]                 dcts_finished,
    input  logic                                quant_slot_done,
    output logic                                dct_nreset,
    output logic                                dct_src_bank,
    output logic [$clog2(GROUPS_PER_STRIP)-1:0] mcu_group,
    output logic [$clog2(OUT_SLOTS)-1:0]        dct_write_slot,
    output logic [$clog2(OUT_SLOTS)-1:0]        quant_read_slot,
    output logic                                slot_ready,
    output logic                                strip_done,
    output logic                                busy,
    output logic                                overrun_err,
    output logic                                protocol_err
);

    localparam int GW = $clog2(GROUPS_PER_STRIP);
    localparam int SW = $clog2(OUT_SLOTS);
    localparam int CW = $clog2(OUT_SLOTS + 1);
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [CW-1:0] FULL       = CW'(OUT_SLOTS);
    localparam logic [GW-1:0] LAST_GROUP = GW'(GROUPS_PER_STRIP - 1);
    localparam logic [RW-1:0] RC_LAST    = RW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RESET_DCTS,
        ACTIVE,
        WAIT_SLOT,
        ERROR
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            prev_sel;
    logic            swap;
    logic            commit;
    logic            read_ok;
    logic            last_group;
    logic            room;
    logic            in_strip;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [SW-1:0]   wr_ptr;
    logic [SW-1:0]   rd_ptr;
    logic [RW-1:0]   rst_cnt;

    assign swap       = ingester_frontbuffer_select != prev_sel;
    assign last_group = mcu_group == LAST_GROUP;
    assign in_strip   = (state == RESET_DCTS) || (state == ACTIVE) || (state == WAIT_SLOT);

    // A swap during a strip wins over the engines' commit; ring bookkeeping freezes in ERROR.
    assign commit  = (state == ACTIVE) && (&dcts_finished) && !swap;
    assign read_ok = quant_slot_done && (count != '0) && (state != ERROR);
    assign room    = count_next < FULL;

    assign dct_nreset      = state == ACTIVE;
    assign busy            = state != IDLE;
    assign slot_ready      = count != '0;
    assign dct_write_slot  = wr_ptr;
    assign quant_read_slot = rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        count_next = count;
        state_next = state;
        if (commit && !read_ok) begin
            count_next = count + 1'b1;
        end else if (!commit && read_ok) begin
            count_next = count - 1'b1;
        end
        case (state)
            IDLE: begin
                if (swap) begin
                    state_next = room ? RESET_DCTS : WAIT_SLOT;
                end
            end
            RESET_DCTS: begin
                if (swap) begin
                    state_next = ERROR;
                end else if (rst_cnt == RC_LAST) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (swap) begin
                    state_next = ERROR;
                end else if (commit) begin
                    if (last_group) begin
                        state_next = IDLE;
                    end else begin
                        state_next = room ? RESET_DCTS : WAIT_SLOT;
                    end
                end
            end
            WAIT_SLOT: begin
                if (swap) begin
                    state_next = ERROR;
                end else if (room) begin
                    state_next = RESET_DCTS;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_sel     <= 1'b0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rst_cnt      <= '0;
            dct_src_bank <= 1'b0;
            mcu_group    <= '0;
            strip_done   <= 1'b0;
            overrun_err  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            prev_sel   <= ingester_frontbuffer_select;
            count      <= count_next;
            strip_done <= commit && last_group;
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if ((state == RESET_DCTS) && (state_next == RESET_DCTS)) begin
                rst_cnt <= rst_cnt + 1'b1;
            end else begin
                rst_cnt <= '0;
            end
            // The bank the ingester just left holds the complete strip.
            if ((state == IDLE) && swap) begin
                dct_src_bank <= prev_sel;
                mcu_group    <= '0;
            end else if (commit) begin
                mcu_group <= last_group ? '0 : mcu_group + 1'b1;
            end
            if (swap && in_strip) begin
                overrun_err <= 1'b1;
            end
            if (quant_slot_done && (count == '0)) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dct_strip_scheduler.sv
// Bench for dct_strip_scheduler: directed strip scenarios and randomized traffic,
// checked against a slot-credit and release-time scoreboard.
module tb_dct_strip_scheduler;

    localparam int NUM_DCTS = 5;
    localparam int GROUPS   = 8;
    localparam int RST_CYC  = 3;
    localparam int SLOTS    = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                sel   = 1'b0;
    logic                qdone = 1'b0;
    logic [NUM_DCTS-1:0] fin   = '0;
    logic                dct_nreset, dct_src_bank, slot_ready, strip_done, busy;
    logic                overrun_err, protocol_err;
    logic [2:0]          mcu_group;
    logic [1:0]          dct_write_slot, quant_read_slot;
    logic [13:0]         obs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int eng_age = 0;

    // Scoreboard: slots written/consumed so far, group in progress, and the absolute
    // edge at which the engines are due out of reset (-1 while waiting for a free slot).
    int m_wr, m_rd, m_group, m_release;
    bit m_strip, m_err, m_ovr, m_prot, m_done, m_bank, m_prev;

    dct_strip_scheduler dut (
        .clock                       (clock),
        .reset                       (reset),
        .ingester_frontbuffer_select (sel),
        .dcts_finished               (fin),
        .quant_slot_done             (qdone),
        .dct_nreset                  (dct_nreset),
        .dct_src_bank                (dct_src_bank),
        .mcu_group                   (mcu_group),
        .dct_write_slot              (dct_write_slot),
        .quant_read_slot             (quant_read_slot),
        .slot_ready                  (slot_ready),
        .strip_done                  (strip_done),
        .busy                        (busy),
        .overrun_err                 (overrun_err),
        .protocol_err                (protocol_err)
    );

    assign obs = {dct_nreset, dct_src_bank, mcu_group, dct_write_slot, quant_read_slot,
                  slot_ready, strip_done, busy, overrun_err, protocol_err};

    always #5 clock = ~clock;

    function automatic int occ();
        return m_wr - m_rd;
    endfunction

    function automatic bit m_nreset();
        return m_strip && !m_err && (m_release >= 0) && (cyc >= m_release);
    endfunction

    function automatic logic [13:0] model_vec();
        return {m_nreset(), m_bank, 3'(m_group), 2'(m_wr % SLOTS), 2'(m_rd % SLOTS),
                occ() != 0, m_done, m_strip || m_err, m_ovr, m_prot};
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_group = 0; m_release = -1;
        m_strip = 0; m_err = 0; m_ovr = 0; m_prot = 0; m_done = 0; m_bank = 0; m_prev = 0;
    endtask

    // One clock edge: update the scoreboard from the inputs present at the edge,
    // then leave time 1 unit past the edge for sampling and driving.
    task automatic tick();
        bit sw, act;
        @(posedge clock);
        if (reset) begin
            model_reset();
            cyc++;
        end else begin
            act = m_nreset();
            cyc++;
            sw = sel != m_prev;
            m_done = 0;
            if (qdone && occ() == 0) m_prot = 1;
            if (!m_err) begin
                if (qdone && occ() != 0) m_rd++;
                if (sw && m_strip) begin
                    m_err = 1;
                    m_ovr = 1;
                end else begin
                    if (sw) begin
                        m_strip = 1; m_bank = m_prev; m_group = 0; m_release = -1;
                    end else if (act && (&fin)) begin
                        m_wr++;
                        if (m_group == GROUPS - 1) begin
                            m_strip = 0; m_group = 0; m_done = 1;
                        end else begin
                            m_group++;
                            m_release = -1;
                        end
                    end
                    if (m_strip && m_release < 0 && occ() < SLOTS) m_release = cyc + RST_CYC;
                end
            end
            m_prev = sel;
        end
        #1;
    endtask

    // Engines report done `delay` cycles after release; before that at least one is busy.
    task automatic drive_engines(input int delay);
        logic [NUM_DCTS-1:0] r;
        r = NUM_DCTS'($urandom);
        if (dct_nreset) begin
            eng_age++;
            if (eng_age >= delay) r = '1;
            else r[$urandom_range(0, NUM_DCTS - 1)] = 1'b0;
        end else begin
            eng_age = 0;
        end
        fin = r;
    endtask

    task automatic do_reset();
        reset = 1'b1; sel = 1'b0; qdone = 1'b0; fin = '0; eng_age = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (obs !== 14'd0) begin
            $display("[TB] FAIL reset_values got %h expected %h", obs, 14'd0);
            errors++;
        end
        checks++;
        tick();
        if (obs !== 14'd0) begin
            $display("[TB] FAIL idle_after_reset got %h expected %h", obs, 14'd0);
            errors++;
        end
        checks++;
    endtask

    task automatic test_full_strip();
        int n = 0, groups_seen = 0, low_run = 0, dones = 0;
        bit prev_nr = 0;
        do_reset();
        sel = 1'b1;
        while (n < 1000) begin
            drive_engines(20);
            qdone = slot_ready;
            tick();
            n++;
            if (obs !== model_vec()) begin
                $display("[TB] FAIL strip_trace cycle %0d got %h expected %h", n, obs, model_vec());
                errors++;
            end
            checks++;
            if (dct_nreset && !prev_nr) begin
                if (low_run !== RST_CYC || mcu_group !== 3'(groups_seen)) begin
                    $display("[TB] FAIL strip_group_start reset_len %0d group %0d expected %0d and %0d",
                             low_run, mcu_group, RST_CYC, groups_seen);
                    errors++;
                end
                checks++;
                groups_seen++;
            end
            low_run = (busy && !dct_nreset) ? low_run + 1 : 0;
            prev_nr = dct_nreset;
            if (strip_done) dones++;
            if (!busy) break;
        end
        qdone = 1'b0;
        fin = '0;
        if (n >= 1000 || groups_seen != GROUPS || dones != 1 || dct_src_bank !== 1'b0) begin
            $display("[TB] FAIL strip_summary cycles %0d groups %0d done_pulses %0d bank %0d expected groups %0d done 1 bank 0",
                     n, groups_seen, dones, dct_src_bank, GROUPS);
            errors++;
        end
        checks++;
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic exp_nr;
        do_reset();
        sel = 1'b1;
        while (n < 400 && occ() < SLOTS) begin
            drive_engines(4);
            tick();
            n++;
            if (obs !== model_vec()) begin
                $display("[TB] FAIL bp_fill cycle %0d got %h expected %h", n, obs, model_vec());
                errors++;
            end
            checks++;
        end
        if (n >= 400 || {slot_ready, dct_write_slot, mcu_group, quant_read_slot} !== {1'b1, 2'd0, 3'd4, 2'd0}) begin
            $display("[TB] FAIL bp_full got %b expected %b",
                     {slot_ready, dct_write_slot, mcu_group, quant_read_slot}, {1'b1, 2'd0, 3'd4, 2'd0});
            errors++;
        end
        checks++;
        for (int k = 0; k < 10; k++) begin
            drive_engines(4);
            tick();
            if ({dct_nreset, busy} !== 2'b01) begin
                $display("[TB] FAIL bp_park got nreset/busy %b expected 01", {dct_nreset, busy});
                errors++;
            end
            checks++;
        end
        qdone = 1'b1;
        drive_engines(100);
        tick();
        qdone = 1'b0;
        if ({dct_nreset, quant_read_slot, slot_ready} !== {1'b0, 2'd1, 1'b1}) begin
            $display("[TB] FAIL bp_release got %b expected %b",
                     {dct_nreset, quant_read_slot, slot_ready}, {1'b0, 2'd1, 1'b1});
            errors++;
        end
        checks++;
        for (int k = 1; k <= 3; k++) begin
            drive_engines(100);
            tick();
            exp_nr = (k == 3);
            if (dct_nreset !== exp_nr) begin
                $display("[TB] FAIL bp_reset_width step %0d got %b expected %b", k, dct_nreset, exp_nr);
                errors++;
            end
            checks++;
        end
        if ({mcu_group, dct_write_slot} !== {3'd4, 2'd0}) begin
            $display("[TB] FAIL bp_group4_slot got %b expected %b", {mcu_group, dct_write_slot}, {3'd4, 2'd0});
            errors++;
        end
        checks++;
        fin = '0;
    endtask

    task automatic test_simultaneous();
        int n = 0;
        logic exp_nr;
        do_reset();
        sel = 1'b1;
        while (n < 400 && !(m_wr == 3 && m_nreset())) begin
            drive_engines(3);
            tick();
            n++;
        end
        fin = '1;
        qdone = 1'b1;
        tick();
        qdone = 1'b0;
        fin = '0;
        if (n >= 400 || {slot_ready, dct_write_slot, quant_read_slot, mcu_group, dct_nreset} !==
                        {1'b1, 2'd0, 2'd1, 3'd4, 1'b0}) begin
            $display("[TB] FAIL simul_commit_read got %b expected %b",
                     {slot_ready, dct_write_slot, quant_read_slot, mcu_group, dct_nreset},
                     {1'b1, 2'd0, 2'd1, 3'd4, 1'b0});
            errors++;
        end
        checks++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_nr = (k == 3);
            if (dct_nreset !== exp_nr) begin
                $display("[TB] FAIL simul_no_wait step %0d got %b expected %b", k, dct_nreset, exp_nr);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_overrun();
        int n = 0;
        do_reset();
        sel = 1'b1;
        while (n < 600 && !(m_strip && m_group == 3 && m_nreset())) begin
            drive_engines(5);
            qdone = slot_ready;
            tick();
            n++;
        end
        sel = 1'b0;
        fin = '1;
        qdone = 1'b0;
        tick();
        if (n >= 600 || {overrun_err, dct_nreset, mcu_group, dct_write_slot, busy, strip_done} !==
                        {1'b1, 1'b0, 3'd3, 2'd3, 1'b1, 1'b0}) begin
            $display("[TB] FAIL overrun_enter got %b expected %b",
                     {overrun_err, dct_nreset, mcu_group, dct_write_slot, busy, strip_done},
                     {1'b1, 1'b0, 3'd3, 2'd3, 1'b1, 1'b0});
            errors++;
        end
        checks++;
        for (int k = 0; k < 6; k++) begin
            sel = 1'($urandom);
            fin = NUM_DCTS'($urandom);
            tick();
            if ({mcu_group, dct_write_slot, dct_nreset, overrun_err} !== {3'd3, 2'd3, 1'b0, 1'b1}) begin
                $display("[TB] FAIL overrun_hold got %b expected %b",
                         {mcu_group, dct_write_slot, dct_nreset, overrun_err}, {3'd3, 2'd3, 1'b0, 1'b1});
                errors++;
            end
            checks++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (obs !== 14'd0) begin
            $display("[TB] FAIL overrun_cleared got %h expected %h", obs, 14'd0);
            errors++;
        end
        checks++;
        sel = 1'b0;
        fin = '0;
    endtask

    task automatic test_protocol();
        logic exp_nr;
        do_reset();
        qdone = 1'b1;
        tick();
        qdone = 1'b0;
        if ({protocol_err, slot_ready, dct_write_slot, quant_read_slot, busy} !== {1'b1, 1'b0, 2'd0, 2'd0, 1'b0}) begin
            $display("[TB] FAIL protocol_empty got %b expected %b",
                     {protocol_err, slot_ready, dct_write_slot, quant_read_slot, busy}, {1'b1, 1'b0, 2'd0, 2'd0, 1'b0});
            errors++;
        end
        checks++;
        sel = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_nr = (k == 3);
            if ({dct_nreset, mcu_group, protocol_err} !== {exp_nr, 3'd0, 1'b1}) begin
                $display("[TB] FAIL protocol_schedule step %0d got %b expected %b",
                         k, {dct_nreset, mcu_group, protocol_err}, {exp_nr, 3'd0, 1'b1});
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic exp_nr;
        do_reset();
        sel = 1'b1;
        while (n < 600 && !(m_strip && m_group == 2 && !m_nreset())) begin
            drive_engines(4);
            qdone = slot_ready;
            tick();
            n++;
        end
        reset = 1'b1; sel = 1'b0; qdone = 1'b0; fin = '0;
        tick();
        reset = 1'b0;
        if (n >= 600 || obs !== 14'd0) begin
            $display("[TB] FAIL midreset_values got %h expected %h", obs, 14'd0);
            errors++;
        end
        checks++;
        tick();
        if (obs !== 14'd0) begin
            $display("[TB] FAIL midreset_idle got %h expected %h", obs, 14'd0);
            errors++;
        end
        checks++;
        sel = 1'b1;
        tick();
        if ({busy, mcu_group, dct_write_slot, dct_src_bank, dct_nreset} !== {1'b1, 3'd0, 2'd0, 1'b0, 1'b0}) begin
            $display("[TB] FAIL midreset_restart got %b expected %b",
                     {busy, mcu_group, dct_write_slot, dct_src_bank, dct_nreset}, {1'b1, 3'd0, 2'd0, 1'b0, 1'b0});
            errors++;
        end
        checks++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_nr = (k == 3);
            if (dct_nreset !== exp_nr) begin
                $display("[TB] FAIL midreset_release step %0d got %b expected %b", k, dct_nreset, exp_nr);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int dly = 4;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (eng_age == 0) dly = $urandom_range(1, 10);
            drive_engines(dly);
            qdone = ($urandom_range(0, 2) == 0);
            if (!busy && $urandom_range(0, 7) == 0) sel = ~sel;
            else if (busy && $urandom_range(0, 399) == 0) sel = ~sel;
            reset = (m_err && $urandom_range(0, 5) == 0) || ($urandom_range(0, 999) == 0);
            tick();
            if (obs !== model_vec()) begin
                $display("[TB] FAIL random_trace cycle %0d got %h expected %h", n, obs, model_vec());
                errors++;
            end
            checks++;
        end
        reset = 1'b0;
        qdone = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_strip();
        test_backpressure();
        test_simultaneous();
        test_overrun();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
